// File: rtl/moore_input_conditioner.sv
// Input conditioner: two-flop synchronizer, counter-based debouncer and
// registered rise/fall pulse generation for one raw external input.
// The debounced level only changes after the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clock edges.
module moore_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic inputClk,
   input  logic inputR,
   input  logic inputX,
   output logic outputX,
   output logic outputRise,
   output logic outputFall,
   output logic outputBusy
);

   // Last count value before a qualified change is committed.
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] countNext;
   logic             levelNext;
   logic             mismatch;

   // Debounce decision: count consecutive disagreements, commit on the last one.
   always_comb begin
      countNext = '0;
      levelNext = outputX;
      mismatch  = (sync2 != outputX);
      if (mismatch) begin
         if (count == LAST_COUNT) begin
            levelNext = sync2;
            countNext = '0;
         end else begin
            countNext = count + CNT_W'(1);
         end
      end
   end

   // State register: synchronizer chain, counter, level and registered pulses.
   always_ff @(posedge inputClk) begin
      if (inputR) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         count      <= '0;
         outputX    <= 1'b0;
         outputRise <= 1'b0;
         outputFall <= 1'b0;
         outputBusy <= 1'b0;
      end else begin
         sync1      <= inputX;
         sync2      <= sync1;
         count      <= countNext;
         outputX    <= levelNext;
         // Pulses coincide with the first cycle the new level is visible.
         outputRise <= levelNext & ~outputX;
         outputFall <= ~levelNext & outputX;
         outputBusy <= (countNext != '0);
      end
   end

endmodule

// File: tb/tb_moore_input_conditioner.sv
// Bench for moore_input_conditioner: directed scenarios followed by random
// bursts, every edge compared against a history-based reference model.
module tb_moore_input_conditioner;

   localparam int D = 4;

   logic clk;
   logic inputR;
   logic inputX;
   logic outputX;
   logic outputRise;
   logic outputFall;
   logic outputBusy;

   int checks;
   int failures;

   // Reference model state.
   bit mS1, mS2, mLvl, mRise, mFall, mBusy;
   bit hist[$];
   int riseSeen;
   int fallSeen;

   moore_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
      .inputClk  (clk),
      .inputR    (inputR),
      .inputX    (inputX),
      .outputX   (outputX),
      .outputRise(outputRise),
      .outputFall(outputFall),
      .outputBusy(outputBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: the level flips once the last D synchronized samples all disagree
   // with it; busy means the trailing run of disagreements is non-empty.
   task automatic modelEdge(input bit x, input bit r);
      bit s2Pre;
      int run;
      if (r) begin
         mS1 = 0; mS2 = 0; mLvl = 0; mRise = 0; mFall = 0; mBusy = 0;
         hist.delete();
      end else begin
         s2Pre = mS2;
         mS2 = mS1;
         mS1 = x;
         hist.push_back(s2Pre);
         if (hist.size() > D) void'(hist.pop_front());
         run = 0;
         for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != mLvl) run++;
            else break;
         end
         mRise = 0;
         mFall = 0;
         if (run >= D) begin
            mRise = !mLvl;
            mFall = mLvl;
            mLvl = !mLvl;
            hist.delete();
            mBusy = 0;
         end else begin
            mBusy = (run != 0);
         end
      end
   endtask

   task automatic step(input bit x, input bit r, input string tag);
      inputX = x;
      inputR = r;
      @(posedge clk);
      modelEdge(x, r);
      #1;
      checks++;
      assert (outputX === mLvl) else begin
         failures++;
         $error("FAIL %s outputX actual=%b expected=%b", tag, outputX, mLvl);
      end
      checks++;
      assert (outputRise === mRise) else begin
         failures++;
         $error("FAIL %s outputRise actual=%b expected=%b", tag, outputRise, mRise);
      end
      checks++;
      assert (outputFall === mFall) else begin
         failures++;
         $error("FAIL %s outputFall actual=%b expected=%b", tag, outputFall, mFall);
      end
      checks++;
      assert (outputBusy === mBusy) else begin
         failures++;
         $error("FAIL %s outputBusy actual=%b expected=%b", tag, outputBusy, mBusy);
      end
      checks++;
      assert (!(outputRise === 1'b1 && outputFall === 1'b1)) else begin
         failures++;
         $error("FAIL %s both_pulses actual=11 expected=not both", tag);
      end
      if (outputRise === 1'b1) riseSeen++;
      if (outputFall === 1'b1) fallSeen++;
      $display("step %-10s inR=%b inX=%b | X=%b rise=%b fall=%b busy=%b", tag, r, x,
               outputX, outputRise, outputFall, outputBusy);
   endtask

   task automatic checkCount(input string tag, input int actual, input int expected);
      checks++;
      assert (actual == expected) else begin
         failures++;
         $error("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   initial begin
      int len;
      bit x;
      bit r;
      checks   = 0;
      failures = 0;
      riseSeen = 0;
      fallSeen = 0;
      inputR   = 1'b1;
      inputX   = 1'b1;

      // Reset held with input high, then release: rise 5 edges after sampling.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "reset");
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "rst_rel");
      checkCount("rst_rel_rises", riseSeen, 1);

      // Clean fall from high level.
      riseSeen = 0; fallSeen = 0;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "fall");
      checkCount("fall_falls", fallSeen, 1);
      checkCount("fall_rises", riseSeen, 0);

      // Bounce: high 3, low 1, then high steady; exactly one rise.
      riseSeen = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "bounce_h");
      step(1'b0, 1'b0, "bounce_l");
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "bounce_s");
      checkCount("bounce_rises", riseSeen, 1);

      // Return low, then a single-cycle glitch must not propagate.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "to_low");
      riseSeen = 0;
      step(1'b1, 1'b0, "glitch");
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "glitch_q");
      checkCount("glitch_rises", riseSeen, 0);

      // Reset mid-qualification, then a full requalification.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "mid_q");
      step(1'b1, 1'b1, "mid_rst");
      riseSeen = 0;
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "requal");
      checkCount("requal_rises", riseSeen, 1);

      // Random bursts with occasional reset.
      for (int b = 0; b < 120; b++) begin
         len = $urandom_range(1, 8);
         x   = 1'($urandom_range(0, 1));
         r   = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < len; i++) step(x, r && (i == 0), "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
